// File: rtl/mem_responder.sv
// mem_responder: MAR/MBR/RAM responder to control-unit strobes with configurable wait states,
//   reporting busy, a one-cycle done pulse and a sticky protocol-error flag.
module mem_responder #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic              mem_clk,
   input  logic              mem_rst_n,
   input  logic              MAR_we,
   input  logic              MAR_mux,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic              MBR_we,
   input  logic              MBR_mux,
   input  logic [DATA_W-1:0] acc_in,
   input  logic              RAM_we,
   output logic [ADDR_W-1:0] mar_out,
   output logic [DATA_W-1:0] mbr_out,
   output logic              mem_busy,
   output logic              mem_done,
   output logic              mem_err
);
   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
   localparam logic [3:0] W = 4'(WAIT_STATES);
   localparam bit NO_WAIT = WAIT_STATES == 0;
   state_t state, state_next;
   logic [3:0] cnt, cnt_next;
   logic [ADDR_W-1:0] addr_l, ram_addr;
   logic [DATA_W-1:0] data_l, mbr_next;
   logic [DATA_W-1:0] ram [DEPTH];
   logic idle, req_rd, req_wr, req_ld, commit, ram_we, done_next, err_next;
   assign mem_busy = state != IDLE;
   always_comb begin
      idle       = state == IDLE;
      req_wr     = idle & RAM_we;
      req_rd     = idle & MBR_we & ~MBR_mux & ~RAM_we;
      req_ld     = idle & MBR_we & MBR_mux & ~RAM_we;
      commit     = !idle && cnt == 4'd1;
      state_next = state;
      cnt_next   = cnt;
      if (!idle) begin
         cnt_next   = cnt - 4'd1;
         state_next = commit ? IDLE : state;
      end else if (!NO_WAIT && (req_rd || req_wr)) begin
         cnt_next   = W;
         state_next = req_wr ? WR_WAIT : RD_WAIT;
      end
      // the write-pending path is gated by reset so an aborted access can never land in RAM
      ram_we    = mem_rst_n & ((req_wr & NO_WAIT) | (commit & state == WR_WAIT));
      ram_addr  = NO_WAIT ? mar_out : addr_l;
      mbr_next  = req_ld ? acc_in :
                  (req_rd & NO_WAIT) ? ram[mar_out] :
                  (commit & state == RD_WAIT) ? ram[addr_l] : mbr_out;
      done_next = req_ld | (NO_WAIT & (req_rd | req_wr)) | commit;
      err_next  = mem_err | (idle & MBR_we & RAM_we) | (~idle & (MAR_we | MBR_we | RAM_we));
   end
   always_ff @(posedge mem_clk)
      if (ram_we) ram[ram_addr] <= NO_WAIT ? mbr_out : data_l;
   always_ff @(posedge mem_clk or negedge mem_rst_n)
      if (!mem_rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         mar_out  <= '0;
         mbr_out  <= '0;
         addr_l   <= '0;
         data_l   <= '0;
         mem_done <= 1'b0;
         mem_err  <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         mbr_out  <= mbr_next;
         mem_done <= done_next;
         mem_err  <= err_next;
         if (idle && MAR_we) mar_out <= MAR_mux ? addr_in : pc_in;
         if (idle) begin
            addr_l <= mar_out;
            data_l <= mbr_out;
         end
      end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of mem_responder across wait-state configurations 0, 2, 3 and 4.
module tb_mem_responder;
   localparam int WS[4] = '{0, 2, 3, 4};
   logic mem_clk, mem_rst_n;
   logic mar_we, mar_mux, mbr_we, mbr_mux, ram_we;
   logic [7:0] pc, addr, acc;
   logic [7:0] mar_o [4];
   logic [7:0] mbr_o [4];
   logic busy_o [4];
   logic done_o [4];
   logic err_o [4];
   int checks = 0, fails = 0;
   for (genvar g = 0; g < 4; g++) begin : g_dut
      mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(WS[g])) u_dut (
         .mem_clk(mem_clk), .mem_rst_n(mem_rst_n),
         .MAR_we(mar_we), .MAR_mux(mar_mux), .pc_in(pc), .addr_in(addr),
         .MBR_we(mbr_we), .MBR_mux(mbr_mux), .acc_in(acc), .RAM_we(ram_we),
         .mar_out(mar_o[g]), .mbr_out(mbr_o[g]), .mem_busy(busy_o[g]),
         .mem_done(done_o[g]), .mem_err(err_o[g])
      );
   end
   initial mem_clk = 1'b0;
   always #5 mem_clk = ~mem_clk;
   task automatic tick();
      @(posedge mem_clk);
      #1;
   endtask
   task automatic strobe(input logic mw, mm, input logic [7:0] p, a, input logic bw, bm,
                         input logic [7:0] c, input logic rw);
      mar_we = mw; mar_mux = mm; pc = p; addr = a;
      mbr_we = bw; mbr_mux = bm; acc = c; ram_we = rw;
      tick();
      mar_we = 0; mbr_we = 0; ram_we = 0;
   endtask
   task automatic do_reset();
      mar_we = 0; mbr_we = 0; ram_we = 0;
      tick();
      mem_rst_n = 0;
      #2;
   endtask
   task automatic release_reset();
      tick();
      mem_rst_n = 1;
      tick();
   endtask
   task automatic wait_done(input int k, output int busy_n, output bit got);
      busy_n = 0;
      got = 0;
      for (int i = 0; i < 20 && !got; i++)
         if (done_o[k]) got = 1;
         else begin
            if (busy_o[k]) busy_n++;
            tick();
         end
   endtask
   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      strobe(1, 0, a, 0, 1, 1, d, 0);
      strobe(0, 0, 0, 0, 0, 0, 0, 1);
      repeat (6) tick();
   endtask
   task automatic test_reset();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         checks++; if ({mar_o[k], mbr_o[k], busy_o[k], done_o[k], err_o[k]} !== 19'h0) begin
            fails++; $display("FAIL reset_outs[%0d]: got mar=%h mbr=%h busy=%b done=%b err=%b want all 0",
                              k, mar_o[k], mbr_o[k], busy_o[k], done_o[k], err_o[k]); end
      end
      release_reset();
   endtask
   task automatic test_read_w0();
      int bn; bit got;
      do_reset(); release_reset();
      preload(8'h10, 8'hA5);
      strobe(0, 0, 0, 0, 1, 1, 8'h00, 0);
      strobe(1, 0, 8'h10, 0, 0, 0, 0, 0);
      checks++; if (done_o[0] !== 1'b0) begin fails++; $display("FAIL rd0_mar_nodone: got %b want 0", done_o[0]); end
      strobe(0, 0, 0, 0, 1, 0, 0, 0);
      checks++; if (mbr_o[0] !== 8'hA5) begin fails++; $display("FAIL rd0_mbr: got %h want a5", mbr_o[0]); end
      checks++; if (done_o[0] !== 1'b1 || busy_o[0] !== 1'b0) begin
         fails++; $display("FAIL rd0_done_busy: got done=%b busy=%b want 1 0", done_o[0], busy_o[0]); end
      wait_done(0, bn, got);
      tick();
      checks++; if (done_o[0] !== 1'b0 || bn != 0) begin
         fails++; $display("FAIL rd0_pulse: got done=%b busy_cycles=%0d want 0 0", done_o[0], bn); end
   endtask
   task automatic test_write_w3();
      int bn; bit got;
      do_reset(); release_reset();
      strobe(1, 1, 0, 8'h20, 1, 1, 8'h3C, 0);
      strobe(0, 0, 0, 0, 0, 0, 0, 1);
      wait_done(2, bn, got);
      checks++; if (!got || bn != 3) begin fails++; $display("FAIL wr3_busy: got done=%b busy_cycles=%0d want 1 3", got, bn); end
      checks++; if (busy_o[2] !== 1'b0) begin fails++; $display("FAIL wr3_busy_done: got busy=%b want 0", busy_o[2]); end
      tick();
      checks++; if (done_o[2] !== 1'b0) begin fails++; $display("FAIL wr3_pulse: got %b want 0", done_o[2]); end
      strobe(0, 0, 0, 0, 1, 1, 8'h00, 0);
      strobe(0, 0, 0, 0, 1, 0, 0, 0);
      wait_done(2, bn, got);
      checks++; if (!got || mbr_o[2] !== 8'h3C) begin fails++; $display("FAIL wr3_readback: got %h done=%b want 3c", mbr_o[2], got); end
   endtask
   task automatic test_busy_err();
      int bn; bit got;
      do_reset(); release_reset();
      preload(8'h40, 8'h77);
      strobe(0, 0, 0, 0, 1, 1, 8'h00, 0);
      checks++; if (err_o[1] !== 1'b0) begin fails++; $display("FAIL be_err_pre: got %b want 0", err_o[1]); end
      strobe(0, 0, 0, 0, 1, 0, 0, 0);
      strobe(1, 1, 0, 8'h55, 0, 0, 0, 0);
      checks++; if (mar_o[1] !== 8'h40 || err_o[1] !== 1'b1) begin
         fails++; $display("FAIL be_ignore: got mar=%h err=%b want 40 1", mar_o[1], err_o[1]); end
      wait_done(1, bn, got);
      checks++; if (!got || mbr_o[1] !== 8'h77) begin fails++; $display("FAIL be_read: got %h done=%b want 77", mbr_o[1], got); end
      repeat (3) tick();
      checks++; if (err_o[1] !== 1'b1 || mar_o[1] !== 8'h40) begin
         fails++; $display("FAIL be_sticky: got err=%b mar=%h want 1 40", err_o[1], mar_o[1]); end
   endtask
   task automatic test_conflict();
      int bn; bit got;
      do_reset(); release_reset();
      preload(8'h60, 8'h5A);
      strobe(0, 0, 0, 0, 1, 1, 8'hC3, 0);
      strobe(0, 0, 0, 0, 1, 0, 8'hEE, 1);
      checks++; if (err_o[1] !== 1'b1 || busy_o[1] !== 1'b1) begin
         fails++; $display("FAIL cf_err: got err=%b busy=%b want 1 1", err_o[1], busy_o[1]); end
      wait_done(1, bn, got);
      checks++; if (!got || bn != 2 || mbr_o[1] !== 8'hC3) begin
         fails++; $display("FAIL cf_write: got mbr=%h busy_cycles=%0d done=%b want c3 2 1", mbr_o[1], bn, got); end
      strobe(0, 0, 0, 0, 1, 1, 8'h00, 0);
      strobe(0, 0, 0, 0, 1, 0, 0, 0);
      wait_done(1, bn, got);
      checks++; if (!got || mbr_o[1] !== 8'hC3) begin fails++; $display("FAIL cf_readback: got %h want c3", mbr_o[1]); end
   endtask
   task automatic test_reset_abort();
      int bn; bit got;
      do_reset(); release_reset();
      preload(8'h30, 8'h11);
      strobe(0, 0, 0, 0, 1, 1, 8'h99, 0);
      strobe(0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      mem_rst_n = 0;
      #1;
      checks++; if ({mar_o[3], mbr_o[3], busy_o[3], done_o[3], err_o[3]} !== 19'h0) begin
         fails++; $display("FAIL ra_async: got mar=%h mbr=%h busy=%b done=%b err=%b want all 0",
                           mar_o[3], mbr_o[3], busy_o[3], done_o[3], err_o[3]); end
      release_reset();
      repeat (5) tick();
      checks++; if (busy_o[3] !== 1'b0 || done_o[3] !== 1'b0) begin
         fails++; $display("FAIL ra_idle: got busy=%b done=%b want 0 0", busy_o[3], done_o[3]); end
      strobe(1, 0, 8'h30, 0, 0, 0, 0, 0);
      strobe(0, 0, 0, 0, 1, 0, 0, 0);
      wait_done(3, bn, got);
      checks++; if (!got || bn != 4 || mbr_o[3] !== 8'h11) begin
         fails++; $display("FAIL ra_ram: got %h busy_cycles=%0d done=%b want 11 4 1", mbr_o[3], bn, got); end
   endtask
   task automatic test_back_to_back();
      logic [7:0] a [3];
      logic [7:0] v [3];
      int dones = 0;
      a = '{8'hFE, 8'hFF, 8'h00};
      v = '{8'h12, 8'h34, 8'h56};
      for (int i = 0; i < 3; i++) preload(a[i], v[i]);
      do_reset(); release_reset();
      for (int i = 0; i < 3; i++) begin
         strobe(1, 0, a[i], 0, 0, 0, 0, 0);
         checks++; if (mar_o[0] !== a[i]) begin fails++; $display("FAIL b2b_mar[%0d]: got %h want %h", i, mar_o[0], a[i]); end
         strobe(0, 0, 0, 0, 1, 0, 0, 0);
         if (done_o[0] === 1'b1) dones++;
         checks++; if (mbr_o[0] !== v[i]) begin fails++; $display("FAIL b2b_mbr[%0d]: got %h want %h", i, mbr_o[0], v[i]); end
      end
      checks++; if (dones != 3 || err_o[0] !== 1'b0) begin
         fails++; $display("FAIL b2b_done_err: got dones=%0d err=%b want 3 0", dones, err_o[0]); end
   endtask
   initial begin
      mem_rst_n = 1;
      mar_we = 0; mar_mux = 0; mbr_we = 0; mbr_mux = 0; ram_we = 0;
      pc = 0; addr = 0; acc = 0;
      test_reset();
      test_read_w0();
      test_write_w3();
      test_busy_err();
      test_conflict();
      test_reset_abort();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
